mpls_egress_demux: RTL and testbench



---
 rtl/mpls_egress_demux_if.sv | 55 +++++
 rtl/mpls_egress_demux.sv | 272 +++++++++++++++++++++++++++
 tb/tb_mpls_egress_demux.sv | 243 ++++++++++++++++++++++++
 3 files changed

// File: rtl/mpls_egress_demux_if.sv
// ---------------------------------------------------------------------------------------------
// mpls_egress_demux_if
//   AXI-Stream bundle used on the converged egress bus and on every per-physical-port output
//   of mpls_egress_demux.
//
//   Parameters
//     DATA_BYTES  bytes per beat (tdata is 8*DATA_BYTES bits wide)
//     USER_WIDTH  tuser width; on the converged bus it carries the destination port index
//     ID_WIDTH    tid width
//     DEST_WIDTH  tdest width
//
//   Modports
//     master  drives tvalid/tdata/tkeep/tstrb/tlast/tid/tdest/tuser, samples tready
//     slave   samples the payload fields, drives tready
// ---------------------------------------------------------------------------------------------
interface mpls_egress_demux_if #(
    parameter int unsigned DATA_BYTES = 64,
    parameter int unsigned USER_WIDTH = 8,
    parameter int unsigned ID_WIDTH   = 4,
    parameter int unsigned DEST_WIDTH = 4
);
    logic                    tvalid;
    logic                    tready;
    logic [8*DATA_BYTES-1:0] tdata;
    logic [DATA_BYTES-1:0]   tkeep;
    logic [DATA_BYTES-1:0]   tstrb;
    logic                    tlast;
    logic [ID_WIDTH-1:0]     tid;
    logic [DEST_WIDTH-1:0]   tdest;
    logic [USER_WIDTH-1:0]   tuser;

    modport master (
        output tvalid,
        output tdata,
        output tkeep,
        output tstrb,
        output tlast,
        output tid,
        output tdest,
        output tuser,
        input  tready
    );

    modport slave (
        input  tvalid,
        input  tdata,
        input  tkeep,
        input  tstrb,
        input  tlast,
        input  tid,
        input  tdest,
        input  tuser,
        output tready
    );
endinterface

// File: rtl/mpls_egress_demux.sv
// ---------------------------------------------------------------------------------------------
// mpls_egress_demux
//   Splits the converged egress AXIS bus from the router core into NUM_EG_PHYS_PORTS
//   per-physical-port AXIS streams. The destination port index is taken from tuser on the
//   first beat of each packet. Packets addressed to a non-existent port are swallowed, and
//   packets longer than MTU_BYTES are cut at MAX_BEATS beats with a forced tlast; the rest of
//   such a packet is swallowed.
//
//   A single output register is shared by all ports: the payload fields fan out to every port
//   and only the selected port sees tvalid. Latency is one cycle, throughput one beat/cycle.
//
//   Ports
//     clk_ifc            core clock, rising edge
//     sreset_ifc         synchronous active-high reset
//     converged_eg_bus   AXIS slave, converged egress bus (tuser = destination port index)
//     eg_phys_ports[]    AXIS masters, one per egress physical port (tuser driven 0)
//     invalid_port_drop  one-cycle pulse: first beat of a packet with an invalid index
//     mtu_truncate       one-cycle pulse: beat on which an over-MTU packet was cut
//     eg_pkt_count[]     packets forwarded per port (statistics build only, else 0)
//     drop_count         packets dropped or truncated (statistics build only, else 0)
//
//   Build option
//     MPLS_EGRESS_DEMUX_STATS_EN  define to generate the saturating packet/drop counters;
//                                 when undefined the counter outputs are tied to 0.
// ---------------------------------------------------------------------------------------------
module mpls_egress_demux #(
    parameter int unsigned NUM_EG_PHYS_PORTS = 4,
    parameter int unsigned MTU_BYTES         = 9600
) (
    input  logic                clk_ifc,
    input  logic                sreset_ifc,
    mpls_egress_demux_if.slave  converged_eg_bus,
    mpls_egress_demux_if.master eg_phys_ports [NUM_EG_PHYS_PORTS-1:0],
    output logic                invalid_port_drop,
    output logic                mtu_truncate,
    output logic [31:0]         eg_pkt_count  [NUM_EG_PHYS_PORTS-1:0],
    output logic [31:0]         drop_count
);

    localparam int unsigned DATA_BYTES = converged_eg_bus.DATA_BYTES;
    localparam int unsigned USER_WIDTH = converged_eg_bus.USER_WIDTH;
    localparam int unsigned ID_WIDTH   = converged_eg_bus.ID_WIDTH;
    localparam int unsigned DEST_WIDTH = converged_eg_bus.DEST_WIDTH;

    localparam int unsigned PORT_IDX_W = (NUM_EG_PHYS_PORTS > 1) ? $clog2(NUM_EG_PHYS_PORTS) : 1;
    localparam int unsigned SEL_SPAN   = 2 ** PORT_IDX_W;
    localparam int unsigned MAX_BEATS  = (MTU_BYTES + DATA_BYTES - 1) / DATA_BYTES;
    localparam int unsigned CNT_W      = $clog2(MAX_BEATS + 1);

    localparam logic [PORT_IDX_W:0] NUM_PORTS = NUM_EG_PHYS_PORTS[PORT_IDX_W:0];
    localparam logic [CNT_W-1:0]    CNT_MAX   = MAX_BEATS[CNT_W-1:0];

    // Elaboration-time sanity checks
    if (NUM_EG_PHYS_PORTS < 1) begin : g_bad_ports
        $error("mpls_egress_demux: NUM_EG_PHYS_PORTS must be >= 1");
    end
    if (USER_WIDTH < PORT_IDX_W) begin : g_bad_user
        $error("mpls_egress_demux: converged_eg_bus USER_WIDTH must be >= PORT_IDX_W");
    end

    typedef enum logic [1:0] {
        StIdle,
        StFwd,
        StDrop
    } state_e;

    state_e state_q, state_d;

    // Shared output register
    logic [8*DATA_BYTES-1:0] data_q;
    logic [DATA_BYTES-1:0]   keep_q;
    logic [DATA_BYTES-1:0]   strb_q;
    logic                    last_q;
    logic [ID_WIDTH-1:0]     id_q;
    logic [DEST_WIDTH-1:0]   dest_q;
    logic                    out_valid_q;
    logic [PORT_IDX_W-1:0]   sel_q;

    logic [CNT_W-1:0]        beat_cnt_q, beat_cnt_d;
    logic                    invalid_q, invalid_d;
    logic                    trunc_q, trunc_d;

    // Padded to a power of two so sel_q can index it without going out of range.
    logic [SEL_SPAN-1:0]     port_ready;

    logic                    reg_free;
    logic                    drain;
    logic                    in_ready;
    logic                    accept;
    logic [PORT_IDX_W-1:0]   user_idx;
    logic                    idx_valid;
    logic                    load;
    logic                    force_last;
    logic [PORT_IDX_W-1:0]   load_sel;

    for (genvar p = 0; p < SEL_SPAN; p++) begin : g_ready
        if (p < NUM_EG_PHYS_PORTS) begin : g_real
            assign port_ready[p] = eg_phys_ports[p].tready;
        end else begin : g_pad
            assign port_ready[p] = 1'b0;
        end
    end

    assign drain    = out_valid_q && port_ready[sel_q];
    assign reg_free = !out_valid_q || port_ready[sel_q];
    // DROP never touches the output register, so it can always swallow beats.
    assign in_ready = (state_q == StDrop) ? 1'b1 : reg_free;
    assign accept   = converged_eg_bus.tvalid && in_ready;

    assign converged_eg_bus.tready = in_ready;

    // Any set bit above the index field also makes the destination invalid, so an
    // out-of-range tuser cannot alias onto a real port.
    assign user_idx  = converged_eg_bus.tuser[PORT_IDX_W-1:0];
    assign idx_valid = ((converged_eg_bus.tuser >> PORT_IDX_W) == '0) &&
                       ({1'b0, user_idx} < NUM_PORTS);

    // Next-state / control
    always_comb begin
        state_d    = state_q;
        beat_cnt_d = beat_cnt_q;
        invalid_d  = 1'b0;
        trunc_d    = 1'b0;
        load       = 1'b0;
        force_last = 1'b0;
        load_sel   = sel_q;

        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    if (!idx_valid) begin
                        invalid_d  = 1'b1;
                        beat_cnt_d = '0;
                        if (!converged_eg_bus.tlast) begin
                            state_d = StDrop;
                        end
                    end else begin
                        load     = 1'b1;
                        load_sel = user_idx;
                        if (converged_eg_bus.tlast) begin
                            beat_cnt_d = '0;
                        end else if (MAX_BEATS == 1) begin
                            // Degenerate MTU of one beat: the first beat already fills it.
                            force_last = 1'b1;
                            trunc_d    = 1'b1;
                            beat_cnt_d = CNT_MAX;
                            state_d    = StDrop;
                        end else begin
                            beat_cnt_d = CNT_W'(1);
                            state_d    = StFwd;
                        end
                    end
                end
            end

            StFwd: begin
                if (accept) begin
                    load = 1'b1;
                    if (converged_eg_bus.tlast) begin
                        // A genuine tlast on the MTU beat is not a truncation.
                        beat_cnt_d = '0;
                        state_d    = StIdle;
                    end else if (beat_cnt_q + CNT_W'(1) == CNT_MAX) begin
                        force_last = 1'b1;
                        trunc_d    = 1'b1;
                        beat_cnt_d = CNT_MAX;
                        state_d    = StDrop;
                    end else begin
                        beat_cnt_d = beat_cnt_q + CNT_W'(1);
                    end
                end
            end

            StDrop: begin
                if (accept && converged_eg_bus.tlast) begin
                    beat_cnt_d = '0;
                    state_d    = StIdle;
                end
            end

            default: begin
                beat_cnt_d = '0;
                state_d    = StIdle;
            end
        endcase
    end

    // Control state
    always_ff @(posedge clk_ifc) begin
        if (sreset_ifc) begin
            state_q     <= StIdle;
            out_valid_q <= 1'b0;
            sel_q       <= '0;
            last_q      <= 1'b0;
            beat_cnt_q  <= '0;
            invalid_q   <= 1'b0;
            trunc_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            beat_cnt_q <= beat_cnt_d;
            invalid_q  <= invalid_d;
            trunc_q    <= trunc_d;
            if (load) begin
                out_valid_q <= 1'b1;
                sel_q       <= load_sel;
                last_q      <= converged_eg_bus.tlast || force_last;
            end else if (drain) begin
                out_valid_q <= 1'b0;
            end
        end
    end

    // Payload fields carry no control meaning, so they are left out of reset.
    always_ff @(posedge clk_ifc) begin
        if (load) begin
            data_q <= converged_eg_bus.tdata;
            keep_q <= converged_eg_bus.tkeep;
            strb_q <= converged_eg_bus.tstrb;
            id_q   <= converged_eg_bus.tid;
            dest_q <= converged_eg_bus.tdest;
        end
    end

    for (genvar p = 0; p < NUM_EG_PHYS_PORTS; p++) begin : g_out
        assign eg_phys_ports[p].tvalid = out_valid_q && (sel_q == PORT_IDX_W'(p));
        assign eg_phys_ports[p].tdata  = data_q;
        assign eg_phys_ports[p].tkeep  = keep_q;
        assign eg_phys_ports[p].tstrb  = strb_q;
        assign eg_phys_ports[p].tlast  = last_q;
        assign eg_phys_ports[p].tid    = id_q;
        assign eg_phys_ports[p].tdest  = dest_q;
        assign eg_phys_ports[p].tuser  = '0;
    end

    assign invalid_port_drop = invalid_q;
    assign mtu_truncate      = trunc_q;

`ifdef MPLS_EGRESS_DEMUX_STATS_EN
    logic [31:0] pkt_cnt_q [NUM_EG_PHYS_PORTS];
    logic [31:0] drop_cnt_q;

    always_ff @(posedge clk_ifc) begin
        if (sreset_ifc) begin
            for (int p = 0; p < NUM_EG_PHYS_PORTS; p++) begin
                pkt_cnt_q[p] <= '0;
            end
            drop_cnt_q <= '0;
        end else begin
            // A packet is counted when its last beat (genuine or forced) leaves the port.
            for (int p = 0; p < NUM_EG_PHYS_PORTS; p++) begin
                if (drain && last_q && (sel_q == PORT_IDX_W'(p)) && (pkt_cnt_q[p] != '1)) begin
                    pkt_cnt_q[p] <= pkt_cnt_q[p] + 32'd1;
                end
            end
            if ((invalid_q || trunc_q) && (drop_cnt_q != '1)) begin
                drop_cnt_q <= drop_cnt_q + 32'd1;
            end
        end
    end

    for (genvar p = 0; p < NUM_EG_PHYS_PORTS; p++) begin : g_stats
        assign eg_pkt_count[p] = pkt_cnt_q[p];
    end
    assign drop_count = drop_cnt_q;
`else
    for (genvar p = 0; p < NUM_EG_PHYS_PORTS; p++) begin : g_stats
        assign eg_pkt_count[p] = '0;
    end
    assign drop_count = '0;
`endif

endmodule

// File: tb/tb_mpls_egress_demux.sv
// Directed bench for mpls_egress_demux (4 ports, 64-byte beats, MTU 9600 -> 150 beats).
module tb_mpls_egress_demux;

`ifdef MPLS_EGRESS_DEMUX_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        srst;
    logic [3:0]  rdy;
    logic [3:0]  vld;
    logic [3:0]  olast;
    logic [31:0] odata [4];
    logic [7:0]  ouser [4];
    logic [3:0]  oid   [4];
    logic [3:0]  odest [4];
    logic        invalid_port_drop;
    logic        mtu_truncate;
    logic [31:0] pkt_cnt [3:0];
    logic [31:0] drop_cnt;

    int checks = 0;
    int errors = 0;

    mpls_egress_demux_if #(.DATA_BYTES(64), .USER_WIDTH(8), .ID_WIDTH(4), .DEST_WIDTH(4)) cin ();
    mpls_egress_demux_if #(.DATA_BYTES(64), .USER_WIDTH(8), .ID_WIDTH(4), .DEST_WIDTH(4))
        eg [3:0] ();

    for (genvar g = 0; g < 4; g++) begin : g_tap
        assign eg[g].tready = rdy[g];
        assign vld[g]       = eg[g].tvalid;
        assign olast[g]     = eg[g].tlast;
        assign odata[g]     = eg[g].tdata[31:0];
        assign ouser[g]     = eg[g].tuser;
        assign oid[g]       = eg[g].tid;
        assign odest[g]     = eg[g].tdest;
    end

    mpls_egress_demux #(
        .NUM_EG_PHYS_PORTS(4),
        .MTU_BYTES        (9600)
    ) dut (
        .clk_ifc          (clk),
        .sreset_ifc       (srst),
        .converged_eg_bus (cin),
        .eg_phys_ports    (eg),
        .invalid_port_drop(invalid_port_drop),
        .mtu_truncate     (mtu_truncate),
        .eg_pkt_count     (pkt_cnt),
        .drop_count       (drop_cnt)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int user, input int dat, input bit last);
        cin.tvalid      = 1'b1;
        cin.tuser       = 8'(user);
        cin.tdata       = '0;
        cin.tdata[31:0] = 32'(dat);
        cin.tkeep       = '1;
        cin.tstrb       = '1;
        cin.tlast       = last;
        cin.tid         = 4'h5;
        cin.tdest       = 4'ha;
    endtask

    // Present one beat, check the converged tready, then let the clock edge take it.
    task automatic beat(input int user, input int dat, input bit last, input bit exp_rdy,
                        input string tag);
        drive(user, dat, last);
        #1;
        chk(tag, 64'(cin.tready), 64'(exp_rdy));
        tick();
    endtask

    task automatic idle_in();
        cin.tvalid = 1'b0;
        cin.tlast  = 1'b0;
    endtask

    initial begin
        srst = 1'b1;
        rdy  = 4'hf;
        idle_in();
        cin.tuser = '0;
        cin.tdata = '0;
        cin.tkeep = '0;
        cin.tstrb = '0;
        cin.tid   = '0;
        cin.tdest = '0;
        tick();
        tick();
        srst = 1'b0;
        #1;

        // Reset state
        chk("rst_vld", 64'(vld), 64'h0);
        chk("rst_rdy", 64'(cin.tready), 64'h1);
        chk("rst_inv", 64'(invalid_port_drop), 64'h0);
        chk("rst_trunc", 64'(mtu_truncate), 64'h0);
        chk("rst_pkt0", 64'(pkt_cnt[0]), 64'h0);
        chk("rst_drop", 64'(drop_cnt), 64'h0);

        // 3-beat packet to port 2
        for (int i = 0; i < 3; i++) begin
            beat(2, 100 + i, i == 2, 1'b1, "t1_rdy");
            chk("t1_vld", 64'(vld), 64'h4);
            chk("t1_data", 64'(odata[2]), 64'(100 + i));
            chk("t1_last", 64'(olast[2]), 64'(i == 2));
        end
        chk("t1_user0", 64'(ouser[2]), 64'h0);
        chk("t1_tid", 64'(oid[2]), 64'h5);
        chk("t1_tdest", 64'(odest[2]), 64'ha);
        idle_in();
        tick();
        chk("t1_vld_end", 64'(vld), 64'h0);
        chk("t1_pkt2", 64'(pkt_cnt[2]), STATS ? 64'd1 : 64'd0);

        // Back-to-back: port 1 (2 beats) then port 3 (1 beat), no bubble
        beat(1, 200, 1'b0, 1'b1, "t2_rdy0");
        chk("t2_vld0", 64'(vld), 64'h2);
        chk("t2_data0", 64'(odata[1]), 64'd200);
        beat(1, 201, 1'b1, 1'b1, "t2_rdy1");
        chk("t2_vld1", 64'(vld), 64'h2);
        chk("t2_data1", 64'(odata[1]), 64'd201);
        chk("t2_last1", 64'(olast[1]), 64'h1);
        beat(3, 300, 1'b1, 1'b1, "t2_rdy2");
        chk("t2_vld2", 64'(vld), 64'h8);
        chk("t2_data2", 64'(odata[3]), 64'd300);
        chk("t2_last2", 64'(olast[3]), 64'h1);
        idle_in();
        tick();
        chk("t2_vld_end", 64'(vld), 64'h0);
        chk("t2_pkt1", 64'(pkt_cnt[1]), STATS ? 64'd1 : 64'd0);
        chk("t2_pkt3", 64'(pkt_cnt[3]), STATS ? 64'd1 : 64'd0);

        // Invalid destination (tuser=5), 4 beats swallowed
        for (int i = 0; i < 4; i++) begin
            beat(5, 400 + i, i == 3, 1'b1, "t3_rdy");
            chk("t3_vld", 64'(vld), 64'h0);
            chk("t3_inv", 64'(invalid_port_drop), 64'(i == 0));
        end
        idle_in();
        tick();
        chk("t3_inv_end", 64'(invalid_port_drop), 64'h0);
        chk("t3_drop", 64'(drop_cnt), STATS ? 64'd1 : 64'd0);
        beat(0, 500, 1'b1, 1'b1, "t3_rdy_next");
        chk("t3_vld_next", 64'(vld), 64'h1);
        chk("t3_data_next", 64'(odata[0]), 64'd500);
        chk("t3_last_next", 64'(olast[0]), 64'h1);
        idle_in();
        tick();

        // 160-beat packet to port 0: cut at 150 beats
        for (int i = 0; i < 160; i++) begin
            beat(0, 1000 + i, i == 159, 1'b1, "t4_rdy");
            if (i < 150) begin
                chk("t4_vld", 64'(vld), 64'h1);
                chk("t4_data", 64'(odata[0]), 64'(1000 + i));
                chk("t4_last", 64'(olast[0]), 64'(i == 149));
            end else begin
                chk("t4_vld_drop", 64'(vld), 64'h0);
            end
            chk("t4_trunc", 64'(mtu_truncate), 64'(i == 149));
        end
        idle_in();
        tick();
        chk("t4_pkt0", 64'(pkt_cnt[0]), STATS ? 64'd2 : 64'd0);
        chk("t4_drop", 64'(drop_cnt), STATS ? 64'd2 : 64'd0);

        // Port 1 back-pressure for 10 cycles mid-packet
        beat(1, 600, 1'b0, 1'b1, "t5_rdy0");
        chk("t5_vld0", 64'(vld), 64'h2);
        rdy[1] = 1'b0;
        drive(1, 601, 1'b0);
        for (int k = 0; k < 10; k++) begin
            #1;
            chk("t5_rdy_hold", 64'(cin.tready), 64'h0);
            tick();
            chk("t5_vld_hold", 64'(vld), 64'h2);
            chk("t5_data_hold", 64'(odata[1]), 64'd600);
        end
        rdy[1] = 1'b1;
        #1;
        chk("t5_rdy_resume", 64'(cin.tready), 64'h1);
        tick();
        chk("t5_vld1", 64'(vld), 64'h2);
        chk("t5_data1", 64'(odata[1]), 64'd601);
        beat(1, 602, 1'b1, 1'b1, "t5_rdy2");
        chk("t5_data2", 64'(odata[1]), 64'd602);
        chk("t5_last2", 64'(olast[1]), 64'h1);
        idle_in();
        tick();
        chk("t5_vld_end", 64'(vld), 64'h0);
        chk("t5_pkt1", 64'(pkt_cnt[1]), STATS ? 64'd2 : 64'd0);

        // Reset during beat 2 of a 5-beat packet to port 2
        beat(2, 700, 1'b0, 1'b1, "t6_rdy0");
        chk("t6_vld0", 64'(vld), 64'h4);
        drive(2, 701, 1'b0);
        srst = 1'b1;
        tick();
        chk("t6_vld_rst", 64'(vld), 64'h0);
        chk("t6_inv_rst", 64'(invalid_port_drop), 64'h0);
        chk("t6_trunc_rst", 64'(mtu_truncate), 64'h0);
        chk("t6_pkt0_rst", 64'(pkt_cnt[0]), 64'h0);
        chk("t6_pkt1_rst", 64'(pkt_cnt[1]), 64'h0);
        chk("t6_drop_rst", 64'(drop_cnt), 64'h0);
        srst = 1'b0;
        idle_in();
        #1;
        chk("t6_rdy_idle", 64'(cin.tready), 64'h1);
        tick();
        chk("t6_vld_idle", 64'(vld), 64'h0);
        beat(0, 800, 1'b1, 1'b1, "t6_rdy_new");
        chk("t6_vld_new", 64'(vld), 64'h1);
        chk("t6_data_new", 64'(odata[0]), 64'd800);
        chk("t6_last_new", 64'(olast[0]), 64'h1);
        idle_in();
        tick();
        chk("t6_vld_end", 64'(vld), 64'h0);
        chk("t6_pkt0", 64'(pkt_cnt[0]), STATS ? 64'd1 : 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
